// File: rtl/matdet_seq.sv
// Sequential determinant engine: enumerates permutations with iterative Heap's
// algorithm and accumulates signed products (Leibniz formula) modulo 2^DATA_WIDTH.
module matdet_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_N      = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [$clog2(MAX_N+1)-1:0]          n,
  input  logic [MAX_N*MAX_N*DATA_WIDTH-1:0]   a,
  output logic                                busy,
  output logic                                done,
  output logic [DATA_WIDTH-1:0]               det,
  output logic                                err
);

  localparam int NW = $clog2(MAX_N + 1);
  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
  localparam logic [NW-1:0] NMAX = NW'(MAX_N);

  typedef enum logic [2:0] {IDLE, MUL, ACC, NEXT, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  m [MAX_N*MAX_N];
  logic [NW-1:0]          p [MAX_N];
  logic [NW-1:0]          c [MAX_N];
  logic [NW-1:0]          nl;
  logic [NW-1:0]          k;
  logic [NW-1:0]          i;
  logic                   neg;
  logic [DATA_WIDTH-1:0]  prod;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  elem;
  logic [IW-1:0]          eidx;

  // Element a[k][p[k]] of the latched matrix for the current product term.
  always_comb begin
    eidx = IW'(k * MAX_N) + IW'(p[k]);
    elem = m[eidx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      det   <= '0;
      err   <= 1'b0;
      nl    <= '0;
      k     <= '0;
      i     <= '0;
      neg   <= 1'b0;
      prod  <= '0;
      acc   <= '0;
      for (int unsigned j = 0; j < MAX_N; j++) begin
        p[j] <= '0;
        c[j] <= '0;
      end
      for (int unsigned j = 0; j < MAX_N*MAX_N; j++) begin
        m[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nl   <= n;
            busy <= 1'b1;
            k    <= '0;
            i    <= NW'(1);
            neg  <= 1'b0;
            prod <= DATA_WIDTH'(1);
            acc  <= '0;
            for (int unsigned j = 0; j < MAX_N*MAX_N; j++) begin
              m[j] <= a[j*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int unsigned j = 0; j < MAX_N; j++) begin
              p[j] <= NW'(j);
              c[j] <= '0;
            end
            if (n == '0) begin
              state <= DONE;
              done  <= 1'b1;
              det   <= DATA_WIDTH'(1);
              err   <= 1'b0;
            end else if (n > NMAX) begin
              state <= DONE;
              done  <= 1'b1;
              det   <= '0;
              err   <= 1'b1;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          prod <= prod * elem;
          if (k == nl - NW'(1)) state <= ACC;
          else                  k     <= k + NW'(1);
        end
        ACC: begin
          acc   <= neg ? (acc - prod) : (acc + prod);
          state <= NEXT;
        end
        NEXT: begin
          // done is raised on entry so det/err are valid throughout the DONE cycle.
          if (i == nl) begin
            state <= DONE;
            done  <= 1'b1;
            det   <= acc;
            err   <= 1'b0;
          end else if (c[i] < i) begin
            if (i[0] == 1'b0) begin
              p[0] <= p[i];
              p[i] <= p[0];
            end else begin
              p[c[i]] <= p[i];
              p[i]    <= p[c[i]];
            end
            c[i]  <= c[i] + NW'(1);
            i     <= NW'(1);
            neg   <= ~neg;
            k     <= '0;
            prod  <= DATA_WIDTH'(1);
            state <= MUL;
          end else begin
            c[i] <= '0;
            i    <= i + NW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matdet_seq.sv
// Scoreboard bench for matdet_seq: driver pushes model results, monitor pops on done.
module tb_matdet_seq;

  localparam int DW = 8;
  localparam int MN = 6;
  localparam int NW = $clog2(MN + 1);

  typedef logic [MN*MN*DW-1:0] mat_t;
  typedef struct {
    logic [DW-1:0] det;
    logic          err;
    int            lat;
    int            t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] n = '0;
  mat_t          a = '0;
  logic          busy, done, err;
  logic [DW-1:0] det;

  matdet_seq #(.DATA_WIDTH(DW), .MAX_N(MN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .a(a),
    .busy(busy), .done(done), .det(det), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nfail = 0;

  task automatic check(string name, longint act, longint req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Leibniz reference: walk every n-tuple of column indices, keep permutations,
  // sign from inversion parity.
  function automatic logic [DW-1:0] model_det(int nn, mat_t mat);
    int total, accm, tt, used, inv, pr, mask;
    int d[MN];
    bit ok;
    mask = (1 << DW) - 1;
    if (nn == 0) return DW'(1);
    total = 1;
    for (int q = 0; q < nn; q++) total *= nn;
    accm = 0;
    for (int t = 0; t < total; t++) begin
      tt = t; used = 0; ok = 1'b1; inv = 0; pr = 1;
      for (int r = 0; r < nn; r++) begin
        d[r] = tt % nn;
        tt   = tt / nn;
        if (used[d[r]]) ok = 1'b0;
        used = used | (1 << d[r]);
      end
      if (ok) begin
        for (int r = 0; r < nn; r++)
          for (int s = r + 1; s < nn; s++)
            if (d[r] > d[s]) inv++;
        for (int r = 0; r < nn; r++)
          pr = (pr * int'(mat[(r*MN + d[r])*DW +: DW])) & mask;
        accm = ((inv % 2) != 0) ? (accm - pr) : (accm + pr);
        accm = accm & mask;
      end
    end
    return accm[DW-1:0];
  endfunction

  function automatic mat_t put(mat_t m, int r, int c, int v);
    m[(r*MN + c)*DW +: DW] = v[DW-1:0];
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int j = 0; j < MN*MN; j++) m[j*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  function automatic mat_t mat2(int a00, int a01, int a10, int a11);
    mat_t m = '0;
    m = put(m, 0, 0, a00); m = put(m, 0, 1, a01);
    m = put(m, 1, 0, a10); m = put(m, 1, 1, a11);
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t me;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      check("done_single_cycle", prev_done, 0);
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        me = sbq.pop_front();
        check("det", det, me.det);
        check("err", err, me.err);
        if (me.lat > 0) check("latency", cyc - me.t0 + 1, me.lat);
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (busy && b < 20000) begin
      @(negedge clk);
      b++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Called at a negedge with the DUT idle; scrambles inputs after the start edge.
  task automatic issue(int nn, mat_t mat, int lat, bit expect_done);
    exp_t e;
    e.det = (nn > MN) ? '0 : model_det(nn, mat);
    e.err = (nn > MN);
    e.lat = lat;
    n = NW'(nn);
    a = mat;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.t0 = cyc;
    if (expect_done) sbq.push_back(e);
    start = 1'b0;
    n = NW'($urandom);
    a = rand_mat();
    check("busy_after_start", busy, 1);
  endtask

  task automatic poke_while_busy();
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      if (busy) begin
        start = 1'b1;
        n = NW'($urandom);
        a = rand_mat();
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mat_t m;
    int   nn, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_det", det, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;

    m = '0;
    for (int r = 0; r < 3; r++) m = put(m, r, r, 1);
    issue(3, m, 0, 1'b1);
    wait_idle();

    issue(2, mat2(3, 4, 1, 2), 0, 1'b1);
    wait_idle();
    issue(2, mat2(1, 2, 3, 4), 0, 1'b1);
    wait_idle();

    m = '0;
    m = put(m, 0, 1, 1); m = put(m, 1, 0, 1); m = put(m, 2, 2, 1);
    issue(3, m, 0, 1'b1);
    wait_idle();

    m = rand_mat();
    m = put(m, 0, 0, 7);
    issue(1, m, 4, 1'b1);
    wait_idle();

    issue(0, rand_mat(), 1, 1'b1);
    wait_idle();
    issue(7, rand_mat(), 1, 1'b1);
    wait_idle();

    // Start held through the DONE cycle: ignored there, accepted in the next IDLE.
    issue(2, mat2(3, 4, 1, 2), 0, 1'b1);
    b = 0;
    while (!done && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("done_seen", done, 1);
    n = NW'(2);
    a = mat2(1, 2, 3, 4);
    start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);
    issue(2, mat2(1, 2, 3, 4), 0, 1'b1);
    wait_idle();

    for (int t = 0; t < 150; t++) begin
      nn = $urandom_range(1, 5);
      issue(nn, rand_mat(), 0, 1'b1);
      poke_while_busy();
      wait_idle();
    end
    for (int t = 0; t < 3; t++) begin
      issue(6, rand_mat(), 0, 1'b1);
      poke_while_busy();
      wait_idle();
    end

    // Reset mid-run aborts silently; a start coincident with reset is dropped.
    issue(5, rand_mat(), 0, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    n = NW'(1);
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_det", det, 0);
    check("midreset_err", err, 0);
    check("midreset_done", done, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", busy, 0);
    issue(2, mat2(3, 4, 1, 2), 0, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
